// File: rtl/axi_pkg.sv
// rtl/axi_pkg.sv - shared AXI field widths, burst/response encodings and FSM state
`ifndef ID_BITS
`define ID_BITS 4
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef LEN_BITS
`define LEN_BITS 8
`endif
`ifndef SIZE_BITS
`define SIZE_BITS 3
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

package axi_pkg;

    typedef enum logic [1:0] {
        FIXED = 2'b00,
        INCR  = 2'b01,
        WRAP  = 2'b10
    } burst_e;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        DATA = 2'b01,
        RESP = 2'b10
    } state_e;

endpackage

// File: rtl/axi_burst_addr_gen.sv
// rtl/axi_burst_addr_gen.sv - combinational next-beat byte address for FIXED/INCR/WRAP bursts
module axi_burst_addr_gen
    import axi_pkg::*;
(
    input  logic [`ADDR_WIDTH-1:0] addr_i,
    input  logic [`LEN_BITS-1:0]   len_i,
    input  logic [`SIZE_BITS-1:0]  size_i,
    input  burst_e                 burst_i,
    output logic [`ADDR_WIDTH-1:0] next_addr_o
);

    logic [`ADDR_WIDTH-1:0] step;
    logic [`ADDR_WIDTH-1:0] incr;
    logic [`ADDR_WIDTH-1:0] wrap_mask;

    always_comb begin
        step      = `ADDR_WIDTH'(1) << size_i;
        incr      = addr_i + step;
        // Wrap region is (len+1) beats, aligned to its own size.
        wrap_mask = ((`ADDR_WIDTH'(len_i) + `ADDR_WIDTH'(1)) << size_i) - `ADDR_WIDTH'(1);
        case (burst_i)
            INCR:    next_addr_o = incr;
            WRAP:    next_addr_o = (addr_i & ~wrap_mask) | (incr & wrap_mask);
            default: next_addr_o = addr_i;
        endcase
    end

endmodule

// File: rtl/axi_wr_sram_slave.sv
// rtl/axi_wr_sram_slave.sv - AXI write-only slave into a byte-enabled SRAM; WRAP bursts need AXI_WR_SRAM_WRAP_EN
module axi_wr_sram_slave
    import axi_pkg::*;
#(
    parameter int DEPTH = 256
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [`ID_BITS-1:0]       AWID,
    input  logic [`ADDR_WIDTH-1:0]    AWADDR,
    input  logic [`LEN_BITS-1:0]      AWLEN,
    input  logic [`SIZE_BITS-1:0]     AWSIZE,
    input  logic [1:0]                AWBURST,
    input  logic                      AWVALID,
    output logic                      AWREADY,
    input  logic [`DATA_WIDTH-1:0]    WDATA,
    input  logic [`DATA_WIDTH/8-1:0]  WSTRB,
    input  logic                      WVALID,
    input  logic                      WLAST,
    output logic                      WREADY,
    output logic [`ID_BITS-1:0]       BID,
    output logic [1:0]                BRESP,
    output logic                      BVALID,
    input  logic                      BREADY,
    input  logic [$clog2(DEPTH)-1:0]  rd_addr_i,
    output logic [`DATA_WIDTH-1:0]    rd_data_o
);

    localparam int LANE_BITS = $clog2(`DATA_WIDTH / 8);
    localparam int IDX_BITS  = $clog2(DEPTH);

    state_e                  state_q, state_d;
    logic                    awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
    logic [`ID_BITS-1:0]     bid_q, bid_d, id_q, id_d;
    logic [1:0]              bresp_q, bresp_d;
    logic [`ADDR_WIDTH-1:0]  addr_q, addr_d, next_addr;
    logic [`LEN_BITS-1:0]    len_q, len_d;
    logic [`SIZE_BITS-1:0]   size_q, size_d;
    burst_e                  burst_q, burst_d;
    logic [`LEN_BITS:0]      beat_q, beat_d;
    logic                    err_q, err_d, discard_q, discard_d;
    logic                    aw_hs, w_hs, b_hs, in_range, wr_en, bad_size, bad_wrap;
    logic [IDX_BITS-1:0]     wr_idx;
    logic [`DATA_WIDTH-1:0]  mem [DEPTH];

    assign aw_hs    = AWVALID && awready_q;
    assign w_hs     = WVALID && wready_q;
    assign b_hs     = BREADY && bvalid_q;
    assign in_range = beat_q <= {1'b0, len_q};
    assign wr_en    = w_hs && in_range && !discard_q;
    assign wr_idx   = addr_q[LANE_BITS +: IDX_BITS];
    assign bad_size = AWSIZE > `SIZE_BITS'(LANE_BITS);
`ifdef AXI_WR_SRAM_WRAP_EN
    assign bad_wrap = !(AWLEN inside {`LEN_BITS'(1), `LEN_BITS'(3), `LEN_BITS'(7), `LEN_BITS'(15)});
`else
    assign bad_wrap = 1'b1;
`endif

    axi_burst_addr_gen u_addr_gen (
        .addr_i      (addr_q),
        .len_i       (len_q),
        .size_i      (size_q),
        .burst_i     (burst_q),
        .next_addr_o (next_addr)
    );

    always_comb begin
        state_d   = state_q;
        awready_d = awready_q;
        wready_d  = wready_q;
        bvalid_d  = bvalid_q;
        bid_d     = bid_q;
        bresp_d   = bresp_q;
        id_d      = id_q;
        addr_d    = addr_q;
        len_d     = len_q;
        size_d    = size_q;
        burst_d   = burst_q;
        beat_d    = beat_q;
        err_d     = err_q;
        discard_d = discard_q;
        case (state_q)
            IDLE: begin
                awready_d = 1'b1;
                wready_d  = 1'b0;
                if (aw_hs) begin
                    id_d      = AWID;
                    addr_d    = AWADDR;
                    len_d     = AWLEN;
                    size_d    = AWSIZE;
                    burst_d   = burst_e'(AWBURST);
                    beat_d    = '0;
                    err_d     = 1'b0;
                    discard_d = bad_size || (AWBURST == WRAP && bad_wrap);
                    awready_d = 1'b0;
                    wready_d  = 1'b1;
                    state_d   = DATA;
                end
            end
            DATA: begin
                if (w_hs) begin
                    addr_d = next_addr;
                    // Saturate so a runaway burst can never wrap back into range.
                    beat_d = (&beat_q) ? beat_q : beat_q + 1'b1;
                    if (!in_range || (WLAST && beat_q < {1'b0, len_q}))
                        err_d = 1'b1;
                    if (WLAST) begin
                        wready_d = 1'b0;
                        bvalid_d = 1'b1;
                        bid_d    = id_q;
                        bresp_d  = (err_d || discard_q) ? SLVERR : OKAY;
                        state_d  = RESP;
                    end
                end
            end
            RESP: begin
                if (b_hs) begin
                    bvalid_d  = 1'b0;
                    awready_d = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bid_q     <= '0;
            bresp_q   <= '0;
            id_q      <= '0;
            addr_q    <= '0;
            len_q     <= '0;
            size_q    <= '0;
            burst_q   <= FIXED;
            beat_q    <= '0;
            err_q     <= 1'b0;
            discard_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bid_q     <= bid_d;
            bresp_q   <= bresp_d;
            id_q      <= id_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            size_q    <= size_d;
            burst_q   <= burst_d;
            beat_q    <= beat_d;
            err_q     <= err_d;
            discard_q <= discard_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            for (int b = 0; b < `DATA_WIDTH / 8; b++) begin
                if (WSTRB[b]) mem[wr_idx][8*b +: 8] <= WDATA[8*b +: 8];
            end
        end
    end

    assign rd_data_o = mem[rd_addr_i];
    assign AWREADY   = awready_q;
    assign WREADY    = wready_q;
    assign BVALID    = bvalid_q;
    assign BID       = bid_q;
    assign BRESP     = bresp_q;

endmodule

// File: tb/tb_axi_wr_sram_slave.sv
// tb/tb_axi_wr_sram_slave.sv - directed self-checking bench for axi_wr_sram_slave
`ifndef ID_BITS
`define ID_BITS 4
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef LEN_BITS
`define LEN_BITS 8
`endif
`ifndef SIZE_BITS
`define SIZE_BITS 3
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module tb_axi_wr_sram_slave;

    localparam logic [1:0] B_FIXED = 2'b00;
    localparam logic [1:0] B_INCR  = 2'b01;
    localparam logic [1:0] B_WRAP  = 2'b10;

    logic                     clk_i = 1'b0;
    logic                     rst_ni = 1'b0;
    logic [`ID_BITS-1:0]      AWID = '0;
    logic [`ADDR_WIDTH-1:0]   AWADDR = '0;
    logic [`LEN_BITS-1:0]     AWLEN = '0;
    logic [`SIZE_BITS-1:0]    AWSIZE = '0;
    logic [1:0]               AWBURST = '0;
    logic                     AWVALID = 1'b0;
    logic                     AWREADY;
    logic [`DATA_WIDTH-1:0]   WDATA = '0;
    logic [`DATA_WIDTH/8-1:0] WSTRB = '0;
    logic                     WVALID = 1'b0;
    logic                     WLAST = 1'b0;
    logic                     WREADY;
    logic [`ID_BITS-1:0]      BID;
    logic [1:0]               BRESP;
    logic                     BVALID;
    logic                     BREADY = 1'b0;
    logic [7:0]               rd_addr_i = '0;
    logic [`DATA_WIDTH-1:0]   rd_data_o;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    axi_wr_sram_slave #(.DEPTH(256)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
        .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WLAST(WLAST), .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .rd_addr_i(rd_addr_i), .rd_data_o(rd_data_o)
    );

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic aw_send(input logic [`ID_BITS-1:0] id, input logic [`ADDR_WIDTH-1:0] addr,
                           input logic [`LEN_BITS-1:0] len, input logic [`SIZE_BITS-1:0] size,
                           input logic [1:0] burst);
        int n = 0;
        AWID = id; AWADDR = addr; AWLEN = len; AWSIZE = size; AWBURST = burst; AWVALID = 1'b1;
        while (AWREADY !== 1'b1 && n < 20) begin tick(); n++; end
        if (AWREADY !== 1'b1) begin
            checks++; errors++;
            $display("FAIL aw_timeout: AWREADY=%b required 1", AWREADY);
        end
        tick();
        AWVALID = 1'b0;
    endtask

    task automatic w_send(input logic [`DATA_WIDTH-1:0] data, input logic [3:0] strb, input logic last);
        int n = 0;
        WDATA = data; WSTRB = strb; WLAST = last; WVALID = 1'b1;
        while (WREADY !== 1'b1 && n < 20) begin tick(); n++; end
        if (WREADY !== 1'b1) begin
            checks++; errors++;
            $display("FAIL w_timeout: WREADY=%b required 1", WREADY);
        end
        tick();
        WVALID = 1'b0; WLAST = 1'b0;
    endtask

    task automatic b_take();
        int n = 0;
        BREADY = 1'b1;
        while (BVALID !== 1'b1 && n < 20) begin tick(); n++; end
        if (BVALID !== 1'b1) begin
            checks++; errors++;
            $display("FAIL b_timeout: BVALID=%b required 1", BVALID);
        end
        tick();
        BREADY = 1'b0;
    endtask

    task automatic write_word(input logic [`ADDR_WIDTH-1:0] addr, input logic [31:0] data);
        aw_send('0, addr, 8'd0, 3'd2, B_INCR);
        w_send(data, 4'hF, 1'b1);
        b_take();
    endtask

    task automatic test_reset();
        tick();
        checks++;
        if ({AWREADY, WREADY, BVALID, BID, BRESP} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got aw=%b w=%b b=%b id=%h resp=%b required all 0",
                     AWREADY, WREADY, BVALID, BID, BRESP);
        end
        rst_ni = 1'b1;
        tick();
        checks++;
        if (AWREADY !== 1'b1) begin errors++; $display("FAIL reset_release_awready: got %b required 1", AWREADY); end
    endtask

    task automatic test_single();
        aw_send(4'd3, 32'h10, 8'd0, 3'd2, B_INCR);
        checks++;
        if (AWREADY !== 1'b0 || WREADY !== 1'b1) begin
            errors++; $display("FAIL single_data_state: aw=%b w=%b required 0 1", AWREADY, WREADY);
        end
        w_send(32'hDEADBEEF, 4'hF, 1'b1);
        checks++;
        if (BVALID !== 1'b1 || BRESP !== 2'b00 || BID !== 4'd3) begin
            errors++; $display("FAIL single_bresp: valid=%b resp=%b id=%h required 1 00 3", BVALID, BRESP, BID);
        end
        b_take();
        checks++;
        if (AWREADY !== 1'b1) begin errors++; $display("FAIL single_idle: AWREADY=%b required 1", AWREADY); end
        rd_addr_i = 8'd4; #1;
        checks++;
        if (rd_data_o !== 32'hDEADBEEF) begin errors++; $display("FAIL single_word4: got %h required deadbeef", rd_data_o); end
    endtask

    task automatic test_incr();
        logic [31:0] exp [4];
        exp[0] = 32'h1; exp[1] = 32'hFFFF0002; exp[2] = 32'h3; exp[3] = 32'h4;
        write_word(32'h24, 32'hFFFFFFFF);
        aw_send(4'd1, 32'h20, 8'd3, 3'd2, B_INCR);
        w_send(32'h1, 4'hF, 1'b0);
        w_send(32'h2, 4'b0011, 1'b0);
        w_send(32'h3, 4'hF, 1'b0);
        w_send(32'h4, 4'hF, 1'b1);
        checks++;
        if (BRESP !== 2'b00 || BID !== 4'd1) begin errors++; $display("FAIL incr_bresp: resp=%b id=%h required 00 1", BRESP, BID); end
        b_take();
        for (int i = 0; i < 4; i++) begin
            rd_addr_i = 8'(8 + i); #1;
            checks++;
            if (rd_data_o !== exp[i]) begin errors++; $display("FAIL incr_word%0d: got %h required %h", 8 + i, rd_data_o, exp[i]); end
        end
    endtask

    task automatic test_wrap();
        logic [31:0] exp [4];
        logic [1:0]  exp_resp;
        aw_send(4'd2, 32'h30, 8'd3, 3'd2, B_INCR);
        for (int i = 0; i < 4; i++) w_send(32'h11110000 + 32'(i), 4'hF, i == 3);
        b_take();
        aw_send(4'd7, 32'h38, 8'd3, 3'd2, B_WRAP);
        w_send(32'hAAAAAAAA, 4'hF, 1'b0);
        w_send(32'hBBBBBBBB, 4'hF, 1'b0);
        w_send(32'hCCCCCCCC, 4'hF, 1'b0);
        w_send(32'hDDDDDDDD, 4'hF, 1'b1);
`ifdef AXI_WR_SRAM_WRAP_EN
        exp_resp = 2'b00;
        exp[0] = 32'hCCCCCCCC; exp[1] = 32'hDDDDDDDD; exp[2] = 32'hAAAAAAAA; exp[3] = 32'hBBBBBBBB;
`else
        exp_resp = 2'b10;
        for (int i = 0; i < 4; i++) exp[i] = 32'h11110000 + 32'(i);
`endif
        checks++;
        if (BRESP !== exp_resp || BID !== 4'd7) begin
            errors++; $display("FAIL wrap_bresp: resp=%b id=%h required %b 7", BRESP, BID, exp_resp);
        end
        b_take();
        for (int i = 0; i < 4; i++) begin
            rd_addr_i = 8'(12 + i); #1;
            checks++;
            if (rd_data_o !== exp[i]) begin errors++; $display("FAIL wrap_word%0d: got %h required %h", 12 + i, rd_data_o, exp[i]); end
        end
    endtask

    task automatic test_error();
        logic [31:0] exp [4];
        exp[0] = 32'hE0; exp[1] = 32'hE1; exp[2] = 32'h55550002; exp[3] = 32'h55550003;
        aw_send(4'd0, 32'h40, 8'd3, 3'd2, B_INCR);
        for (int i = 0; i < 4; i++) w_send(32'h55550000 + 32'(i), 4'hF, i == 3);
        b_take();
        aw_send(4'd9, 32'h40, 8'd3, 3'd2, B_INCR);
        w_send(32'hE0, 4'hF, 1'b0);
        w_send(32'hE1, 4'hF, 1'b1);
        checks++;
        if (BVALID !== 1'b1 || BRESP !== 2'b10 || BID !== 4'd9) begin
            errors++; $display("FAIL early_last_bresp: valid=%b resp=%b id=%h required 1 10 9", BVALID, BRESP, BID);
        end
        b_take();
        checks++;
        if (AWREADY !== 1'b1) begin errors++; $display("FAIL early_last_idle: AWREADY=%b required 1", AWREADY); end
        for (int i = 0; i < 4; i++) begin
            rd_addr_i = 8'(16 + i); #1;
            checks++;
            if (rd_data_o !== exp[i]) begin errors++; $display("FAIL early_last_word%0d: got %h required %h", 16 + i, rd_data_o, exp[i]); end
        end
        // extra beat past len+1 is accepted but not written
        write_word(32'h54, 32'h21212121);
        aw_send(4'd4, 32'h50, 8'd0, 3'd2, B_FIXED);
        w_send(32'h20202020, 4'hF, 1'b0);
        w_send(32'hBAD0BAD0, 4'hF, 1'b1);
        checks++;
        if (BRESP !== 2'b10) begin errors++; $display("FAIL extra_beat_bresp: got %b required 10", BRESP); end
        b_take();
        rd_addr_i = 8'd20; #1;
        checks++;
        if (rd_data_o !== 32'h20202020) begin errors++; $display("FAIL extra_beat_word20: got %h required 20202020", rd_data_o); end
        rd_addr_i = 8'd21; #1;
        checks++;
        if (rd_data_o !== 32'h21212121) begin errors++; $display("FAIL extra_beat_word21: got %h required 21212121", rd_data_o); end
        // oversized beat is discarded
        write_word(32'h58, 32'h22222222);
        aw_send(4'd5, 32'h58, 8'd0, 3'd3, B_INCR);
        w_send(32'h0BADF00D, 4'hF, 1'b1);
        checks++;
        if (BRESP !== 2'b10) begin errors++; $display("FAIL bad_size_bresp: got %b required 10", BRESP); end
        b_take();
        rd_addr_i = 8'd22; #1;
        checks++;
        if (rd_data_o !== 32'h22222222) begin errors++; $display("FAIL bad_size_word22: got %h required 22222222", rd_data_o); end
    endtask

    task automatic test_back_to_back();
        aw_send(4'd5, 32'h60, 8'd0, 3'd2, B_INCR);
        w_send(32'h60606060, 4'hF, 1'b1);
        AWID = 4'd6; AWADDR = 32'h64; AWLEN = '0; AWSIZE = 3'd2; AWBURST = B_INCR; AWVALID = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (BVALID !== 1'b1 || BID !== 4'd5 || BRESP !== 2'b00 || AWREADY !== 1'b0) begin
                errors++;
                $display("FAIL backpressure_c%0d: valid=%b id=%h resp=%b awready=%b required 1 5 00 0",
                         i, BVALID, BID, BRESP, AWREADY);
            end
        end
        BREADY = 1'b1;
        tick();
        BREADY = 1'b0;
        checks++;
        if (AWREADY !== 1'b1 || BVALID !== 1'b0) begin
            errors++; $display("FAIL after_b_awready: awready=%b bvalid=%b required 1 0", AWREADY, BVALID);
        end
        tick();
        AWVALID = 1'b0;
        checks++;
        if (AWREADY !== 1'b0 || WREADY !== 1'b1) begin
            errors++; $display("FAIL pending_aw_taken: awready=%b wready=%b required 0 1", AWREADY, WREADY);
        end
        w_send(32'h64646464, 4'hF, 1'b1);
        checks++;
        if (BID !== 4'd6) begin errors++; $display("FAIL pending_aw_bid: got %h required 6", BID); end
        b_take();
        rd_addr_i = 8'd25; #1;
        checks++;
        if (rd_data_o !== 32'h64646464) begin errors++; $display("FAIL pending_aw_word25: got %h required 64646464", rd_data_o); end
    endtask

    task automatic test_reset_mid_burst();
        aw_send(4'd8, 32'h80, 8'd3, 3'd2, B_INCR);
        w_send(32'h77770000, 4'hF, 1'b0);
        w_send(32'h77770001, 4'hF, 1'b0);
        rst_ni = 1'b0;
        #1;
        checks++;
        if ({AWREADY, WREADY, BVALID, BID, BRESP} !== '0) begin
            errors++;
            $display("FAIL mid_reset_outputs: aw=%b w=%b b=%b id=%h resp=%b required all 0",
                     AWREADY, WREADY, BVALID, BID, BRESP);
        end
        tick();
        tick();
        rst_ni = 1'b1;
        tick();
        checks++;
        if (AWREADY !== 1'b1 || BVALID !== 1'b0 || WREADY !== 1'b0) begin
            errors++; $display("FAIL mid_reset_release: aw=%b b=%b w=%b required 1 0 0", AWREADY, BVALID, WREADY);
        end
        for (int i = 0; i < 2; i++) begin
            rd_addr_i = 8'(32 + i); #1;
            checks++;
            if (rd_data_o !== 32'h77770000 + 32'(i)) begin
                errors++; $display("FAIL mid_reset_word%0d: got %h required %h", 32 + i, rd_data_o, 32'h77770000 + 32'(i));
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_incr();
        test_wrap();
        test_error();
        test_back_to_back();
        test_reset_mid_burst();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
